seg_digit_driver: RTL and testbench

Downstream companion to the 4-digit anode scanner FSM: takes a 14-bit binary value, converts it to four BCD digits with a sequential shift-add-3 engine, holds them in a display register, and drives the active-low seven-segment cathodes for whichever digit the scanner's 2-bit digit index currently selects. It sits between the datapath producing the number and the board's cathode pins, running in lockstep with the scanner's anode outputs.

---
 rtl/seg_digit_driver.sv | 255 +++++++++++++++++++++++++
 tb/tb_seg_digit_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_driver.sv
// -----------------------------------------------------------------------------
// seg_digit_driver
//
// Converts a 14-bit binary value into four BCD digits with a sequential
// shift-add-3 (double dabble) engine, keeps the finished result in a display
// register and drives the active-low seven-segment cathodes for whichever
// digit the anode scanner currently selects.
//
// The display register only changes when a conversion commits, so the digit
// pattern never shows partial results while the engine is running.
//
// Parameters
//   BLANK_LZ     1: blank leading zeros on thousands/hundreds/tens digits.
//                The ones digit is always shown.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_load       single-cycle strobe, captures i_value when idle
//   i_value      binary value to display (0-9999 is the displayable range)
//   i_digit_sel  scanner digit index: 0 thousands .. 3 ones
//   o_seg        cathodes {g,f,e,d,c,b,a}, active low, registered
//   o_busy       conversion in progress, i_load ignored while high
//   o_done       one-cycle pulse when the display register updates
//   o_ovf        last accepted value exceeded 9999 (all digits show a dash)
// -----------------------------------------------------------------------------
module seg_digit_driver #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [13:0] i_value,
    input  logic [1:0]  i_digit_sel,
    output logic [6:0]  o_seg,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ovf
);

    // -------------------------------------------------------------------------
    // Segment patterns (active low, {g,f,e,d,c,b,a})
    // -------------------------------------------------------------------------
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [3:0] LAST_ITER = 4'd13;   // 14 shifts: iterations 0..13

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [13:0] r_bin;      // binary shift register, MSB feeds the BCD side
    // BCD accumulator. Bits 15:0 are the four displayed digits; bit 16 is
    // the ten-thousands digit. Inputs are below 2^14 = 16384, so that digit
    // is at most 1 and a single bit holds it exactly. It is set after the
    // last shift precisely when the captured value exceeds 9999, which makes
    // it the overflow flag with no separate magnitude comparator.
    logic [16:0] r_bcd;
    logic [3:0]  r_iter;
    logic [15:0] r_disp;     // display register: {thousands,hundreds,tens,ones}
    logic        r_ovf;
    logic        r_done;
    logic [6:0]  r_seg;

    // -------------------------------------------------------------------------
    // Control wires
    // -------------------------------------------------------------------------
    state_t      w_state_next;
    logic        w_capture;
    logic        w_shift_en;
    logic        w_commit;

    // Datapath wires
    logic [15:0] w_bcd_adj;          // accumulator after the add-3 step
    logic [3:0]  w_digit [4];        // digit by scanner index
    logic [6:0]  w_pat   [4];        // decoded pattern by scanner index
    logic [2:0]  w_lead;             // digit and everything left of it is zero
    logic [3:0]  w_blank;            // leading-zero blank per scanner index
    logic [6:0]  w_seg_next;

    // -------------------------------------------------------------------------
    // Digit decoder; non-decimal nibbles show nothing
    // -------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] p;
        p = SEG_BLANK;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_iter == LAST_ITER) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Add-3 step: every decimal nibble that is 5 or more gets 3 added so the
    // following left shift carries correctly into the next digit. The
    // ten-thousands bit never reaches 5 and needs no correction.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? r_bcd[gi*4 +: 4] + 4'd3
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Conversion engine and display register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;

            if (w_capture) begin
                r_bin  <= i_value;
                r_bcd  <= '0;
                r_iter <= '0;
            end else if (w_shift_en) begin
                // {BCD, binary} shifted left by one, binary MSB enters BCD LSB.
                // The old ten-thousands bit is still zero here: it can only
                // become set on the final shift.
                r_bcd  <= {w_bcd_adj, r_bin[13]};
                r_bin  <= {r_bin[12:0], 1'b0};
                r_iter <= r_iter + 4'd1;
            end

            if (w_commit) begin
                r_ovf <= r_bcd[16];
                // An out-of-range result is thrown away; the dashes cover
                // the whole display while the overflow flag is set.
                if (!r_bcd[16]) begin
                    r_disp <= r_bcd[15:0];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-digit decode and leading-zero detection.
    // Scanner index 0 is the thousands digit, i.e. the top nibble.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign w_digit[gi] = r_disp[(3-gi)*4 +: 4];
            assign w_pat[gi]   = f_decode(w_digit[gi]);
        end

        // Zero run from the left; the ones digit is never part of it.
        for (genvar gi = 0; gi < 3; gi++) begin : g_lead
            if (gi == 0) begin : g_first
                assign w_lead[gi] = (w_digit[gi] == 4'd0);
            end else begin : g_rest
                assign w_lead[gi] = w_lead[gi-1] & (w_digit[gi] == 4'd0);
            end
            assign w_blank[gi] = BLANK_LZ & w_lead[gi];
        end
    endgenerate

    assign w_blank[3] = 1'b0;

    // -------------------------------------------------------------------------
    // Cathode register: one cycle behind i_digit_sel, matching the scanner's
    // registered anode output.
    // -------------------------------------------------------------------------
    always_comb begin
        w_seg_next = w_pat[i_digit_sel];
        if (r_ovf) begin
            w_seg_next = SEG_DASH;
        end else if (w_blank[i_digit_sel]) begin
            w_seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg <= SEG_BLANK;
        end else begin
            r_seg <= w_seg_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_seg  = r_seg;
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seg_digit_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_digit_driver
//
// Directed scoreboard bench. Stimulus pushes expected cathode patterns and
// expected DONE events (cycle, overflow flag) into queues; an independent
// monitor pops and compares whenever the DUT presents a segment sample or a
// DONE pulse.
// -----------------------------------------------------------------------------
module tb_seg_digit_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic [1:0]  sel = '0;
    logic [6:0]  o_seg;
    logic        o_busy;
    logic        o_done;
    logic        o_ovf;

    seg_digit_driver #(.BLANK_LZ(1'b1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (load),
        .i_value     (value),
        .i_digit_sel (sel),
        .o_seg       (o_seg),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ovf       (o_ovf)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to time DONE
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A digit select driven before an edge produces a SEG sample after it
    logic sel_vld = 1'b0;
    logic sel_vld_d = 1'b0;
    always @(posedge clk) sel_vld_d <= sel_vld;

    typedef struct {
        string      name;
        logic [6:0] seg;
    } seg_exp_t;

    typedef struct {
        string name;
        int    cyc;
        logic  ovf;
    } done_exp_t;

    seg_exp_t  seg_q[$];
    done_exp_t done_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    int busy_run = 0;
    always @(negedge clk) begin
        seg_exp_t  se;
        done_exp_t de;
        if (sel_vld_d) begin
            if (seg_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL seg sample with empty queue: got %0h", o_seg);
            end else begin
                se = seg_q.pop_front();
                chk(se.name, o_seg, se.seg);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected DONE at cycle %0d, required none", cyc);
            end else begin
                de = done_q.pop_front();
                chk({de.name, " done cycle"}, cyc, de.cyc);
                chk({de.name, " ovf"}, o_ovf, de.ovf);
                chk({de.name, " busy cycles"}, busy_run, 15);
            end
        end
        busy_run = o_busy ? busy_run + 1 : 0;
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // -------------------------------------------------------------------------
    task automatic pulse_load(input logic [13:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic start(input string tag, input logic [13:0] v, input logic ovf);
        done_exp_t d;
        d.name = tag;
        d.cyc  = cyc + 16;   // LOAD edge is cyc+1, DONE visible after edge +15
        d.ovf  = ovf;
        done_q.push_back(d);
        pulse_load(v);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: DONE not seen within 40 cycles, required a pulse", tag);
        end
    endtask

    task automatic sweep(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] e [4];
        seg_exp_t   s;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            sel     = i[1:0];
            sel_vld = 1'b1;
            s.name  = $sformatf("%s d%0d", tag, i);
            s.seg   = e[i];
            seg_q.push_back(s);
            @(negedge clk);
        end
        sel_vld = 1'b0;
    endtask

    task automatic convert(input string tag, input logic [13:0] v, input logic ovf);
        start(tag, v, ovf);
        wait_done(tag);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge clk);
        chk("reset seg",  o_seg,  7'h7F);
        chk("reset busy", o_busy, 1'b0);
        chk("reset done", o_done, 1'b0);
        chk("reset ovf",  o_ovf,  1'b0);
        rst = 1'b0;
        sweep("after reset", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        convert("1234", 14'd1234, 1'b0);
        sweep("1234", 7'h79, 7'h24, 7'h30, 7'h19);

        convert("9999", 14'd9999, 1'b0);
        sweep("9999", 7'h10, 7'h10, 7'h10, 7'h10);
        convert("0", 14'd0, 1'b0);
        sweep("0", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        convert("7", 14'd7, 1'b0);
        sweep("7", 7'h7F, 7'h7F, 7'h7F, 7'h78);
        convert("305", 14'd305, 1'b0);
        sweep("305", 7'h7F, 7'h30, 7'h40, 7'h12);

        convert("10000", 14'd10000, 1'b1);
        sweep("10000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        convert("16383", 14'd16383, 1'b1);
        sweep("16383", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        convert("42", 14'd42, 1'b0);
        sweep("42", 7'h7F, 7'h7F, 7'h19, 7'h24);

        // Busy conversion: old display held, second LOAD ignored
        start("1234b", 14'd1234, 1'b0);
        sweep("hold 42", 7'h7F, 7'h7F, 7'h19, 7'h24);
        pulse_load(14'd5678);
        wait_done("1234b");
        // LOAD on the DONE cycle is accepted
        start("5678", 14'd5678, 1'b0);
        sweep("hold 1234", 7'h79, 7'h24, 7'h30, 7'h19);
        wait_done("5678");
        sweep("5678", 7'h12, 7'h02, 7'h78, 7'h00);

        // Reset at cycle 7 of a conversion: no DONE, display back to "0"
        pulse_load(14'd4321);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", o_busy, 1'b0);
        chk("abort done", o_done, 1'b0);
        sweep("abort", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        convert("4321", 14'd4321, 1'b0);
        sweep("4321", 7'h19, 7'h30, 7'h24, 7'h79);

        repeat (20) @(negedge clk);
        chk("done queue drained", done_q.size(), 0);
        chk("seg queue drained",  seg_q.size(),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
